// File: rtl/sha_block_assembler_480_if.sv
// Word-stream / block-output bus for sha_block_assembler_480.
// master: word source plus downstream core (drives words, clear, core_ready).
// slave:  the assembler.
interface sha_block_assembler_480_if #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 15,
  parameter int CNT_W     = 4
);
  localparam int BLOCK_W = WORD_W * NUM_WORDS;

  logic               clear;
  logic               in_valid;
  logic [WORD_W-1:0]  in_word;
  logic               in_ready;
  logic               core_ready;
  logic               write_en;
  logic [BLOCK_W-1:0] block_out;
  logic [CNT_W-1:0]   word_cnt;
  logic               block_pend;

  modport master (
    output clear, in_valid, in_word, core_ready,
    input  in_ready, write_en, block_out, word_cnt, block_pend
  );

  modport slave (
    input  clear, in_valid, in_word, core_ready,
    output in_ready, write_en, block_out, word_cnt, block_pend
  );
endinterface

// File: rtl/sha_block_assembler_480.sv
// Packs NUM_WORDS message words into one BLOCK_W block for the SHA-256 block
// save register, then strobes write_en once the downstream core is ready.
// Optional build macro SHA_ASM_BSWAP_EN: byte-reverse each word before storage
// (little-endian sources); default stores words unmodified.
//
// state | meaning
// FILL  | accepting words into slots 0..NUM_WORDS-1
// PEND  | block complete, waiting for core_ready; write_en follows core_ready
module sha_block_assembler_480 #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 15,
  parameter int CNT_W     = 4
) (
  input logic clk,
  input logic rst,
  sha_block_assembler_480_if.slave bus
);
  localparam int BLOCK_W = WORD_W * NUM_WORDS;

  typedef enum logic {FILL = 1'b0, PEND = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               live_q;
  logic               hs;
  logic               last_word;
  logic [WORD_W-1:0]  word_in;
  logic [CNT_W-1:0]   cnt_q;
  logic [BLOCK_W-1:0] blk_q;

  assign bus.word_cnt  = cnt_q;
  assign bus.block_out = blk_q;

  // A word is taken only on a real handshake; clear drops any word offered.
  assign hs        = bus.in_valid && bus.in_ready && !bus.clear;
  assign last_word = (cnt_q == CNT_W'(NUM_WORDS - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Holds in_ready low during reset and until the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) live_q <= 1'b0;
    else     live_q <= 1'b1;
  end

  // Next-state logic; clear overrides everything except reset.
  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (hs && last_word) state_nxt = PEND;
        PEND:    if (bus.core_ready)  state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  // Moore outputs, write_en gated by core_ready and suppressed by clear.
  always_comb begin
    bus.in_ready   = 1'b0;
    bus.block_pend = 1'b0;
    bus.write_en   = 1'b0;
    case (state)
      FILL: bus.in_ready = live_q;
      PEND: begin
        bus.block_pend = 1'b1;
        bus.write_en   = bus.core_ready && !bus.clear;
      end
      default: ;
    endcase
  end

  // Incoming word path: optional byte reversal, otherwise pass-through.
  always_comb begin
    word_in = bus.in_word;
`ifdef SHA_ASM_BSWAP_EN
    for (int b = 0; b < WORD_W / 8; b++) begin
      word_in[b*8 +: 8] = bus.in_word[WORD_W-8-b*8 +: 8];
    end
`endif
  end

  // Word counter: counts accepted words, parks at NUM_WORDS while pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt_q <= '0;
    else if (bus.clear)    cnt_q <= '0;
    else if (bus.write_en) cnt_q <= '0;
    else if (hs)           cnt_q <= cnt_q + 1'b1;
  end

  // Block register: slot k sits at the top-down position k; old contents
  // stay visible until overwritten by the next block's words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q <= '0;
    end else if (hs) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (cnt_q == CNT_W'(k)) blk_q[BLOCK_W-1-k*WORD_W -: WORD_W] <= word_in;
      end
    end
  end
endmodule
